// File: rtl/dmem_line_responder.sv
// Fixed-latency backing store of 256-bit lines answering one cache refill or write-back at a time.
// A request sampled in idle completes LATENCY edges later with a one-cycle ack.
module dmem_line_responder #(
    parameter int unsigned LINES_LOG2 = 9,
    parameter int unsigned LATENCY    = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o
);

    localparam int unsigned NumLines = 2 ** LINES_LOG2;
    localparam logic [7:0]  LastCnt  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e                  r_state;
    logic [7:0]              r_cnt;
    logic                    r_write;
    logic [LINES_LOG2-1:0]   r_idx;
    logic [255:0]            r_wdata;
    logic                    r_ack;
    logic                    r_busy;
    logic [255:0]            r_rdata;
    logic [255:0]            r_mem [NumLines];

    logic                    w_access;
    logic                    w_commit;
    logic [LINES_LOG2-1:0]   w_idx;
    logic                    w_unused_addr;

    assign w_idx         = addr_i[LINES_LOG2+4:5];
    assign w_unused_addr = ^{addr_i[31:LINES_LOG2+5], addr_i[4:0]};

    // Reset on the access edge wins, so neither the commit nor the ack may happen then.
    assign w_access = (r_state == StWait) && (r_cnt == LastCnt) && !rst_i;
    assign w_commit = w_access && r_write;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_ack <= 1'b0;
                    if (req_i) begin
                        r_write <= write_i;
                        r_idx   <= w_idx;
                        r_wdata <= data_i;
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b1;
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == LastCnt) begin
                        r_ack   <= 1'b1;
                        r_state <= StAck;
                        if (!r_write) begin
                            r_rdata <= r_mem[r_idx];
                        end
                    end
                end
                StAck: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Line array has no reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign ack_o  = r_ack;
    assign busy_o = r_busy;
    assign data_o = r_rdata;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Randomized self-checking bench: a LATENCY=10 and a LATENCY=1 instance against a line-array model.
// Transactions are timed in whole cycles from the accepting edge to the observed ack.
module tb_dmem_line_responder;

    logic         clk = 1'b0;
    logic         rst   [2];
    logic         req   [2];
    logic         wr    [2];
    logic [31:0]  addr  [2];
    logic [255:0] din   [2];
    logic         ack   [2];
    logic [255:0] dout  [2];
    logic         busy  [2];

    logic [255:0] mdl       [2][512];
    logic [255:0] exp_dout  [2];
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    dmem_line_responder #(.LINES_LOG2(9), .LATENCY(10)) u_dut0 (
        .clk_i   (clk),
        .rst_i   (rst[0]),
        .req_i   (req[0]),
        .write_i (wr[0]),
        .addr_i  (addr[0]),
        .data_i  (din[0]),
        .ack_o   (ack[0]),
        .data_o  (dout[0]),
        .busy_o  (busy[0])
    );

    dmem_line_responder #(.LINES_LOG2(9), .LATENCY(1)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst[1]),
        .req_i   (req[1]),
        .write_i (wr[1]),
        .addr_i  (addr[1]),
        .data_i  (din[1]),
        .ack_o   (ack[1]),
        .data_o  (dout[1]),
        .busy_o  (busy[1])
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 10 : 1;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 5) % 512);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until ack or the cycle budget runs out; n is edges stepped.
    task automatic wait_ack(input int s, input bit scr, input bit chk_busy, output int n);
        n = 0;
        do begin
            if (scr) begin
                addr[s] = $urandom;
                din[s]  = rnd256();
                wr[s]   = 1'($urandom);
            end
            step();
            n++;
            if (!ack[s] && chk_busy) chk("busy_wait", 256'(busy[s]), 256'(1));
        end while (!ack[s] && n < 300);
        if (!ack[s]) chk("ack_timeout", 256'(0), 256'(1));
    endtask

    task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [255:0] d,
                       input bit scr);
        int           n;
        int           idx;
        logic [255:0] exp;
        idx = line_of(a);
        exp = w ? exp_dout[s] : mdl[s][idx];
        req[s]  = 1'b1;
        wr[s]   = w;
        addr[s] = a;
        din[s]  = d;
        step();
        req[s] = 1'b0;
        chk("busy_rise", 256'(busy[s]), 256'(1));
        wait_ack(s, scr, 1'b1, n);
        chk("latency", 256'(n), 256'(lat_of(s)));
        chk(w ? "wr_dout_hold" : "rd_data", dout[s], exp);
        chk("busy_in_ack", 256'(busy[s]), 256'(1));
        if (w) mdl[s][idx] = d;
        else exp_dout[s] = exp;
        step();
        chk("ack_one_cycle", 256'(ack[s]), 256'(0));
        chk("busy_fall", 256'(busy[s]), 256'(0));
    endtask

    // Starts a write and asserts reset just before edge n_edge after acceptance.
    task automatic abort_write(input logic [31:0] a, input int n_edge);
        int acks;
        req[0]  = 1'b1;
        wr[0]   = 1'b1;
        addr[0] = a;
        din[0]  = 256'hFF;
        step();
        req[0] = 1'b0;
        repeat (n_edge - 1) step();
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        exp_dout[0] = '0;
        chk("abort_busy", 256'(busy[0]), 256'(0));
        chk("abort_dout", dout[0], 256'(0));
        acks = int'(ack[0]);
        repeat (20) begin
            step();
            acks += int'(ack[0]);
        end
        chk("abort_no_ack", 256'(acks), 256'(0));
        txn(0, 1'b0, a, '0, 1'b0);
    endtask

    initial begin
        int           n;
        int           idx;
        logic [31:0]  a;
        logic [255:0] pat;

        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; req[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; din[s] = '0;
            exp_dout[s] = '0;
        end
        repeat (3) step();
        for (int s = 0; s < 2; s++) begin
            chk("rst_ack", 256'(ack[s]), 256'(0));
            chk("rst_busy", 256'(busy[s]), 256'(0));
            chk("rst_dout", dout[s], 256'(0));
            rst[s] = 1'b0;
        end

        // Preload the lines the random phase will touch.
        for (int i = 0; i < 16; i++) txn(0, 1'b1, 32'(i) << 5, rnd256(), 1'b0);
        for (int i = 0; i < 4; i++) txn(1, 1'b1, 32'(i) << 5, rnd256(), 1'b0);

        pat = {8{32'hDEADBEEF}};
        txn(0, 1'b1, 32'h0000_0060, pat, 1'b0);
        txn(0, 1'b0, 32'h0000_0060, '0, 1'b0);

        // Back-to-back: write held into a read of the same line.
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0120; din[0] = 256'h1;
        step();
        wait_ack(0, 1'b0, 1'b1, n);
        chk("b2b_first_lat", 256'(n), 256'(10));
        wr[0] = 1'b0;
        wait_ack(0, 1'b0, 1'b0, n);
        chk("b2b_gap", 256'(n), 256'(12));
        chk("b2b_rd", dout[0], 256'h1);
        req[0] = 1'b0;
        mdl[0][9] = 256'h1;
        exp_dout[0] = 256'h1;
        step();
        chk("b2b_ack_drop", 256'(ack[0]), 256'(0));

        txn(0, 1'b1, 32'h0000_4020, 256'hA5, 1'b0);
        txn(0, 1'b0, 32'h0000_0020, '0, 1'b0);
        chk("alias_a", dout[0], 256'hA5);
        txn(0, 1'b0, 32'h0000_003F, '0, 1'b0);
        chk("alias_b", dout[0], 256'hA5);

        for (int k = 0; k < 40; k++) begin
            idx = int'($urandom_range(15, 0));
            a = ($urandom & 32'hFFFF_C000) | (32'(idx) << 5) | ($urandom & 32'h1F);
            txn(0, 1'($urandom), a, rnd256(), 1'b1);
        end
        for (int k = 0; k < 20; k++) begin
            idx = int'($urandom_range(3, 0));
            a = ($urandom & 32'hFFFF_C000) | (32'(idx) << 5) | ($urandom & 32'h1F);
            txn(1, 1'($urandom), a, rnd256(), 1'b1);
        end

        abort_write(32'h0000_00E0, 5);
        abort_write(32'h0000_0100, 10);

        // LATENCY=1 with req held: ack every 3 cycles.
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0000_0040;
        step();
        wait_ack(1, 1'b0, 1'b1, n);
        chk("l1_first_lat", 256'(n), 256'(1));
        chk("l1_rd", dout[1], mdl[1][2]);
        for (int k = 0; k < 3; k++) begin
            wait_ack(1, 1'b0, 1'b0, n);
            chk("l1_gap", 256'(n), 256'(3));
        end
        req[1] = 1'b0;
        step();
        chk("l1_ack_drop", 256'(ack[1]), 256'(0));
        step();
        chk("l1_busy_fall", 256'(busy[1]), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
